// File: rtl/mux_lane_loader.sv
// mux_lane_loader: packs serial lane words into a flat lane bus and sweeps
// the select index over every lane on command, feeding the lane mux.
module mux_lane_loader #(
  parameter int unsigned size = 4,
  parameter int unsigned n    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_valid,
  input  logic [size-1:0]          wr_data,
  output logic                     wr_ready,
  input  logic                     start,
  output logic [size*(2**n)-1:0]   lanes,
  output logic [n-1:0]             select,
  output logic                     bank_full,
  output logic                     scan_valid,
  output logic                     scan_done
);

  localparam int unsigned lane_count = 2**n;
  localparam int unsigned bus_w      = size * lane_count;
  localparam logic [n-1:0] last_lane = n'(lane_count - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FULL = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t       state;
  logic [n-1:0] wr_ptr;

  // Loader/sweeper FSM; every output is a register updated alongside state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      lanes      <= '0;
      select     <= '0;
      wr_ready   <= 1'b0;
      bank_full  <= 1'b0;
      scan_valid <= 1'b0;
      scan_done  <= 1'b0;
    end else if (clear) begin
      // Restart loading; lane contents are kept and a same-cycle write is dropped.
      state      <= LOAD;
      wr_ptr     <= '0;
      select     <= '0;
      wr_ready   <= 1'b1;
      bank_full  <= 1'b0;
      scan_valid <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          wr_ready <= 1'b1;
          if (wr_valid && wr_ready) begin
            for (int k = 0; k < lane_count; k++) begin
              if (wr_ptr == n'(k)) lanes[k*size +: size] <= wr_data;
            end
            wr_ptr <= wr_ptr + n'(1);
            if (wr_ptr == last_lane) begin
              state     <= FULL;
              wr_ready  <= 1'b0;
              bank_full <= 1'b1;
            end
          end
        end
        FULL: begin
          select     <= '0;
          wr_ready   <= 1'b0;
          bank_full  <= 1'b1;
          scan_done  <= 1'b0;
          if (start) begin
            state      <= SCAN;
            scan_valid <= 1'b1;
          end else begin
            scan_valid <= 1'b0;
          end
        end
        SCAN: begin
          wr_ready  <= 1'b0;
          bank_full <= 1'b1;
          if (select == last_lane) begin
            state      <= FULL;
            select     <= '0;
            scan_valid <= 1'b0;
            scan_done  <= 1'b0;
          end else begin
            select     <= select + n'(1);
            scan_valid <= 1'b1;
            scan_done  <= ((select + n'(1)) == last_lane);
          end
        end
        default: begin
          state      <= LOAD;
          wr_ptr     <= '0;
          select     <= '0;
          wr_ready   <= 1'b0;
          bank_full  <= 1'b0;
          scan_valid <= 1'b0;
          scan_done  <= 1'b0;
        end
      endcase
    end
  end

  // Width sanity for the flat lane bus.
  initial_check: assert property (@(posedge clk) $bits(lanes) == bus_w);

endmodule
